// File: rtl/router_split.sv
// rtl/router_split.sv - joins a data token with a destination token, buffers it and routes it to one of NUM_OUT lanes
module router_split #(
    parameter int WIDTH   = 11,
    parameter int CTRL_W  = 3,
    parameter int NUM_OUT = 5,
    parameter int DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        ctrl_data,
    input  logic                     ctrl_valid,
    output logic                     ctrl_ready,
    output logic [NUM_OUT*WIDTH-1:0] out_data,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [7:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = CTRL_W + WIDTH;
    localparam logic [CTRL_W:0]  NUM_OUT_C = (CTRL_W + 1)'(NUM_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    // Each entry holds {destination, payload}
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              ready_q;
    logic [7:0]        drop_q;

    logic              accept;
    logic              legal;
    logic              push;
    logic              pop;
    logic              drop;
    logic [CTRL_W-1:0] head_dest;
    logic [WIDTH-1:0]  head_data;

    // Pointers wrap explicitly so DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Both channels move together; ready comes only from registered state
    assign accept     = in_valid & ctrl_valid & ready_q;
    assign legal      = {1'b0, ctrl_data} < NUM_OUT_C;
    assign push       = accept & legal;
    assign drop       = accept & ~legal;
    assign {head_dest, head_data} = mem_q[rd_ptr_q];
    assign in_ready   = ready_q;
    assign ctrl_ready = ready_q;
    assign drop_count = drop_q;

    // Decode the head destination into a lane; only that lane's ready may pop
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_valid[k]               = (count_q != '0) && (head_dest == CTRL_W'(k));
            out_data[k*WIDTH +: WIDTH] = head_data;
        end
        pop = |(out_valid & out_ready);
    end

    // Occupancy after this cycle's push/pop; simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, pointers, registered ready and saturating drop counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {ctrl_data, in_data};
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_d;
            ready_q <= (count_d != FULL_CNT);
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_router_split.sv
// tb/tb_router_split.sv - self-checking bench for router_split against a queue model
module tb_router_split;

    localparam int W  = 11;
    localparam int CW = 3;
    localparam int NO = 5;
    localparam int D  = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [W-1:0]      in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CW-1:0]     ctrl_data = '0;
    logic              ctrl_valid = 1'b0;
    logic              ctrl_ready;
    logic [NO*W-1:0]   out_data;
    logic [NO-1:0]     out_valid;
    logic [NO-1:0]     out_ready = '0;
    logic [7:0]        drop_count;

    router_split #(.WIDTH(W), .CTRL_W(CW), .NUM_OUT(NO), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ctrl_data  (ctrl_data),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [CW-1:0] dest;
        logic [W-1:0]  data;
    } tok_t;

    tok_t         mq[$];
    int           m_drop = 0;
    logic         m_ready = 1'b0;
    logic [W-1:0] obs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a token queue; legal codes join the tail, the head leaves when its lane is ready
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_drop  = 0;
            m_ready = 1'b0;
        end else begin
            bit acc;
            acc = in_valid && ctrl_valid && m_ready;
            if (mq.size() > 0 && out_ready[mq[0].dest]) void'(mq.pop_front());
            if (acc) begin
                if (int'(ctrl_data) < NO) mq.push_back('{ctrl_data, in_data});
                else if (m_drop < 255) m_drop++;
            end
            m_ready = (mq.size() < D);
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_ctrl_ready", 64'(ctrl_ready), 64'd0);
            chk("rst_drop", 64'(drop_count), 64'd0);
            chk("rst_out_data", 64'(out_data), 64'd0);
        end else begin
            logic [NO-1:0] ev;
            ev = (mq.size() > 0) ? (NO'(1) << mq[0].dest) : '0;
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'(m_ready));
            chk("ctrl_ready", 64'(ctrl_ready), 64'(m_ready));
            chk("drop_count", 64'(drop_count), 64'(m_drop));
            if (mq.size() > 0) begin
                chk("out_data_lane", 64'(out_data[mq[0].dest*W +: W]), 64'(mq[0].data));
                if (out_ready[mq[0].dest]) obs.push_back(out_data[mq[0].dest*W +: W]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc();
        int g = 0;
        bit acc;
        do begin
            acc = in_ready;
            @(posedge clk);
            #1;
            g++;
        end while (!acc && g < 50);
        chk("accepted", 64'(acc), 64'd1);
        in_valid   = 1'b0;
        ctrl_valid = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [CW-1:0] c);
        in_data    = d;
        ctrl_data  = c;
        in_valid   = 1'b1;
        ctrl_valid = 1'b1;
        wait_acc();
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        int cycles;
        bit acc;
        #1 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("post_reset_ready", 64'(in_ready), 64'd1);

        // T2 routing
        out_ready = '1;
        for (int k = 0; k < NO; k++) begin
            send(11'h155, CW'(k));
            chk("t2_valid", 64'(out_valid), 64'(1) << k);
            chk("t2_data", 64'(out_data[k*W +: W]), 64'h155);
        end
        cyc(2);

        // T3 illegal codes
        send(11'h7FF, 3'd5);
        send(11'h7FF, 3'd6);
        send(11'h7FF, 3'd7);
        chk("t3_valid", 64'(out_valid), 64'd0);
        chk("t3_drop3", 64'(drop_count), 64'd3);
        for (int i = 0; i < 300; i++) send(11'h7FF, CW'(5 + i % 3));
        chk("t3_drop_sat", 64'(drop_count), 64'd255);

        // T4 join: control alone is held off
        ctrl_data  = 3'd4;
        in_data    = 11'h0AA;
        ctrl_valid = 1'b1;
        in_valid   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t4_held_valid", 64'(out_valid), 64'd0);
            chk("t4_ready_high", 64'(ctrl_ready), 64'd1);
        end
        in_valid = 1'b1;
        wait_acc();
        chk("t4_out_valid", 64'(out_valid), 64'b10000);
        chk("t4_out_data", 64'(out_data[4*W +: W]), 64'h0AA);
        cyc(1);
        chk("t4_single", 64'(out_valid), 64'd0);

        // T5 backpressure on lane 2
        obs.delete();
        out_ready = 5'b11011;
        send(11'h101, 3'd2);
        send(11'h102, 3'd2);
        chk("t5_full", 64'(in_ready), 64'd0);
        in_data    = 11'h103;
        ctrl_data  = 3'd2;
        in_valid   = 1'b1;
        ctrl_valid = 1'b1;
        cyc(3);
        chk("t5_blocked_valid", 64'(out_valid), 64'b00100);
        chk("t5_blocked_ready", 64'(in_ready), 64'd0);
        out_ready = '1;
        wait_acc();
        cyc(3);
        chk("t5_count", 64'(obs.size()), 64'd3);
        for (int i = 0; i < 3 && i < obs.size(); i++) chk("t5_order", 64'(obs[i]), 64'(11'h101 + i));

        // T6 full-rate streaming, alternating lanes 1 and 3
        obs.delete();
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            in_data    = W'(11'h200 + i);
            ctrl_data  = (i % 2 != 0) ? 3'd3 : 3'd1;
            in_valid   = 1'b1;
            ctrl_valid = 1'b1;
            do begin
                acc = in_ready;
                @(posedge clk);
                #1;
                cycles++;
            end while (!acc && cycles < 200);
        end
        in_valid   = 1'b0;
        ctrl_valid = 1'b0;
        cyc(3);
        chk("t6_cycles", 64'(cycles), 64'd20);
        chk("t6_count", 64'(obs.size()), 64'd20);
        for (int i = 0; i < 20 && i < obs.size(); i++) chk("t6_order", 64'(obs[i]), 64'(11'h200 + i));

        // T1 reset with tokens buffered
        obs.delete();
        out_ready = '0;
        send(11'h03C, 3'd1);
        send(11'h03D, 3'd3);
        chk("t1_full", 64'(in_ready), 64'd0);
        reset = 1'b1;
        #2;
        chk("t1_rst_valid", 64'(out_valid), 64'd0);
        chk("t1_rst_drop", 64'(drop_count), 64'd0);
        cyc(2);
        reset = 1'b0;
        out_ready = '1;
        cyc(6);
        chk("t1_no_token", 64'(obs.size()), 64'd0);
        chk("t1_idle_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
